// File: rtl/rotating_pattern_nx.sv
// rotating_pattern_nx: animates a looping square or a perimeter-chasing segment across an
// N-digit multiplexed common-anode seven-segment display, with speed, direction and pause/step.
module rotating_pattern_nx #(
  parameter int NUM_DIGITS  = 4,
  parameter int STEP_DIV    = 50_000_000,
  parameter int REFRESH_DIV = 50_000,
  parameter int PW          = $clog2(2*NUM_DIGITS+4)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cw,
  input  logic                  mode,
  input  logic [1:0]            speed,
  input  logic                  step,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic [PW-1:0]         pos,
  output logic                  wrap
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(STEP_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST_SQ  = PW'(2*NUM_DIGITS-1);
  localparam logic [PW-1:0] LAST_PER = PW'(2*NUM_DIGITS+3);

  logic [SW-1:0] step_cnt;
  logic [SW-1:0] step_last;
  logic          step_tick;
  logic          mode_q;
  logic          advance;
  logic [PW-1:0] last_pos;
  logic [RW-1:0] ref_cnt;
  logic [DW-1:0] scan;
  logic [DW-1:0] tgt;
  logic [7:0]    pat;
  int            pos_i;

  // >= compare so that shortening the period mid-count ticks on the very next cycle
  assign step_last = SW'((STEP_DIV >> speed) - 1);
  assign advance   = (en && step_tick) || (!en && step);
  assign last_pos  = mode_q ? LAST_PER : LAST_SQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
      mode_q    <= 1'b0;
      pos       <= '0;
      wrap      <= 1'b0;
    end else if (mode != mode_q) begin
      mode_q    <= mode;
      pos       <= '0;
      step_cnt  <= '0;
      step_tick <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (step_cnt >= step_last) begin
        step_cnt  <= '0;
        step_tick <= 1'b1;
      end else begin
        step_cnt  <= step_cnt + SW'(1);
        step_tick <= 1'b0;
      end
      wrap <= 1'b0;
      if (advance) begin
        if (cw) begin
          if (pos == last_pos) begin
            pos  <= '0;
            wrap <= 1'b1;
          end else begin
            pos <= pos + PW'(1);
          end
        end else if (pos == '0) begin
          pos  <= last_pos;
          wrap <= 1'b1;
        end else begin
          pos <= pos - PW'(1);
        end
      end
    end
  end

  // scan wraps explicitly at N-1 so non-power-of-two digit counts work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      scan    <= '0;
    end else if (ref_cnt == RW'(REFRESH_DIV-1)) begin
      ref_cnt <= '0;
      scan    <= (scan == DW'(NUM_DIGITS-1)) ? '0 : scan + DW'(1);
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_comb begin
    pos_i = int'(pos);
    tgt   = '0;
    pat   = 8'hFF;
    if (!mode_q) begin
      if (pos_i < NUM_DIGITS) begin
        tgt = DW'(pos_i);
        pat = 8'h9C;
      end else begin
        tgt = DW'(2*NUM_DIGITS-1-pos_i);
        pat = 8'hA3;
      end
    end else if (pos_i < NUM_DIGITS) begin
      tgt = DW'(NUM_DIGITS-1-pos_i);
      pat = 8'hFE;
    end else if (pos_i == NUM_DIGITS) begin
      tgt = '0;
      pat = 8'hFD;
    end else if (pos_i == NUM_DIGITS+1) begin
      tgt = '0;
      pat = 8'hFB;
    end else if (pos_i <= 2*NUM_DIGITS+1) begin
      tgt = DW'(pos_i-NUM_DIGITS-2);
      pat = 8'hF7;
    end else if (pos_i == 2*NUM_DIGITS+2) begin
      tgt = DW'(NUM_DIGITS-1);
      pat = 8'hEF;
    end else begin
      tgt = DW'(NUM_DIGITS-1);
      pat = 8'hDF;
    end
  end

  assign an  = ~(NUM_DIGITS'(1) << scan);
  assign seg = (scan == tgt) ? pat : 8'hFF;

endmodule
